rsu_param_sequencer: RTL
========================

Name: rsu_param_sequencer

Overview:
- Sequences all parameter transactions to the remote-system-update IP (read_param/write_param/param/read_source/data_in/data_out/busy).
- Shares the IP between two requesters: port 0 is the boot-address discovery FSM; port 1 is the host IO-register path.
- Owns the IP's watchdog refresh (reset_timer) and gates the reconfig trigger so reconfig is never issued mid-transaction.
- Sits between the IO-mapped update peripheral and the vendor IP instance.

Parameters:
- CTimeout, 1024, cycles a transaction may wait on busy before it is aborted with an error; minimum 4.
- CWdtLog, 8, width of the free-running watchdog counter. Its MSB drives reset_timer.
- CMinWait, 2, cycles after the issue pulse before busy is sampled; covers the IP's busy-rise latency.

Ports:
- AClkH  in  1  clock.
- AResetHN  in  1  asynchronous active-low reset.
- AClkHEn  in  1  clock enable; no state changes when low.
- AReqA  in  1  requester 0 (boot FSM) request, level.
- AWrA  in  1  requester 0 direction: 1 = write, 0 = read.
- AParamA  in  3  requester 0 param index.
- ASrcA  in  2  requester 0 read_source.
- AMosiA  in  32  requester 0 write data.
- AReqB  in  1  requester 1 (host) request, level.
- AWrB  in  1  requester 1 direction: 1 = write, 0 = read.
- AParamB  in  3  requester 1 param index.
- ASrcB  in  2  requester 1 read_source.
- AMosiB  in  32  requester 1 write data.
- ADoneA  out  1  one-cycle completion pulse for requester 0.
- ADoneB  out  1  one-cycle completion pulse for requester 1.
- AMiso  out  32  captured read data; valid from Done until the next capture.
- AErr  out  1  set together with Done when the transaction timed out; cleared at the next grant.
- ABusy  out  1  high from grant until Done, inclusive.
- AReconfigReq  in  1  host reconfig request, one-cycle pulse.
- ORsuReadParam  out  1  read strobe to the IP.
- ORsuWriteParam  out  1  write strobe to the IP.
- ORsuParam  out  3  param index to the IP.
- ORsuSrc  out  2  read_source to the IP.
- ORsuDataIn  out  32  write data to the IP.
- IRsuBusy  in  1  busy from the IP.
- IRsuDataOut  in  32  read data from the IP.
- ORsuResetTimer  out  1  watchdog refresh to the IP.
- ORsuReconfig  out  1  reconfig to the IP; sticky once set.

Behaviour:
- Reset values: all outputs 0, state Idle, watchdog counter 0, reconfig-pending flag 0.
- Every register update is qualified by AClkHEn. With AClkHEn low, all state holds and Done pulses stretch; callers run on the same enable.
- FSM states: Idle, Issue, Wait, Capture, Done.
- Idle: if AReqA, grant A; else if AReqB, grant B. Fixed priority, A wins ties. Grant latches requester id, Wr, Param, Src and Mosi into ORsu* registers. Go to Issue.
- Issue: exactly one cycle. ORsuReadParam = ~Wr; ORsuWriteParam = Wr. Load wait counter 0. Go to Wait.
- Wait: counter increments each enabled cycle.
  - When counter >= CMinWait and IRsuBusy = 0: go to Capture.
  - When counter reaches CTimeout-1 with busy still high: set error, go to Done.
- Capture: AMiso <= IRsuDataOut on reads; AMiso unchanged on writes. Go to Done.
- Done: pulse the granted requester's Done for one cycle. AErr reflects the timeout. Return to Idle.
- Earliest-case latency, grant cycle to Done pulse: 1 (Issue) + CMinWait (Wait) + 1 (Capture) + 1 (Done). With CMinWait = 2 and busy already low, Done appears 5 cycles after the grant cycle.
- Back-to-back requests: Idle is visited for at least 1 cycle between transactions. A requester still holding Req in the Done cycle is re-granted one cycle later, subject to priority.
- Starvation: B may starve while A asserts continuously. This is accepted because the boot FSM runs only after reset.
- ORsu* param/src/data hold their last value outside Issue; the strobes are 0 outside Issue.
- Watchdog: the CWdtLog-bit counter free-runs and wraps 2^CWdtLog-1 -> 0. ORsuResetTimer = counter MSB.
- Reconfig:
  - AReconfigReq sets a pending flag.
  - When pending and state = Idle, ORsuReconfig is set and stays set until reset.
  - A pulse arriving mid-transaction is deferred to the next Idle, never dropped.
  - A pulse in the same cycle as a new grant defers reconfig until that transaction completes.
- Async reset mid-transaction: return to Idle immediately; no Done is issued; strobes drop at once.

Decomposition:
- Shared package rsu_pkg holds:
  - state encoding constants (one-hot, 5 bits);
  - the IP field widths (param 3, src 2, data 32);
  - the requester id constants.
- One sub-module, rsu_wdt_counter (free-running counter with MSB output), reusable by the other update-IP variant.
- Arbitration stays inline; it is two-way fixed priority.

Test Plan:
- Reset; AReqB read, Param=4, Src=2; IP model holds busy for 3 cycles and returns 0x12345678 -> ORsuReadParam pulses once with ORsuParam=4 and ORsuSrc=2; ADoneB pulses once; AMiso=0x12345678; AErr=0.
- AReqA and AReqB raised in the same cycle, both reads -> A served first (ADoneA), then B granted one cycle after Idle; no overlap of strobes.
- AReqA write, AMosiA=0x00ABCDEF -> ORsuWriteParam pulses once with ORsuDataIn=0x00ABCDEF; ORsuReadParam stays 0; AMiso unchanged.
- Busy held high permanently with CTimeout=16 -> ADone pulses with AErr=1 at Wait count 15; the next grant clears AErr.
- AReconfigReq pulsed during Wait -> ORsuReconfig stays 0 until the cycle after Done returns the FSM to Idle, then goes to 1 and stays there.
- AClkHEn toggling 1-of-3 with CWdtLog=4 -> ORsuResetTimer period = 48 AClkH cycles; transaction latency scales by 3 exactly.

Source files
------------

// File: rtl/rsu_pkg.sv
// Shared definitions for the remote-system-update parameter sequencer family.
package rsu_pkg;

    localparam int unsigned CParamW = 3;
    localparam int unsigned CSrcW   = 2;
    localparam int unsigned CDataW  = 32;

    typedef enum logic [4:0] {
        ST_IDLE    = 5'b00001,
        ST_ISSUE   = 5'b00010,
        ST_WAIT    = 5'b00100,
        ST_CAPTURE = 5'b01000,
        ST_DONE    = 5'b10000
    } state_e;

    localparam logic CReqIdA = 1'b0;
    localparam logic CReqIdB = 1'b1;

endpackage

// File: rtl/rsu_wdt_counter.sv
// Free-running watchdog counter; its MSB is the refresh toggle for the update IP.
module rsu_wdt_counter #(
    parameter int unsigned CWidth = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic msb
);

    logic [CWidth-1:0] count_r;

    // Counter wraps naturally at 2^CWidth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= '0;
        end else if (en) begin
            count_r <= count_r + CWidth'(1);
        end
    end

    assign msb = count_r[CWidth-1];

endmodule

// File: rtl/rsu_param_sequencer.sv
// Arbitrates two requesters onto the update IP's parameter interface, refreshes
// its watchdog and holds off reconfig until no transaction is in flight.
module rsu_param_sequencer
    import rsu_pkg::*;
#(
    parameter int unsigned CTimeout = 1024,
    parameter int unsigned CWdtLog  = 8,
    parameter int unsigned CMinWait = 2
) (
    input  logic              AClkH,
    input  logic              AResetHN,
    input  logic              AClkHEn,
    input  logic              AReqA,
    input  logic              AWrA,
    input  logic [CParamW-1:0] AParamA,
    input  logic [CSrcW-1:0]  ASrcA,
    input  logic [CDataW-1:0] AMosiA,
    input  logic              AReqB,
    input  logic              AWrB,
    input  logic [CParamW-1:0] AParamB,
    input  logic [CSrcW-1:0]  ASrcB,
    input  logic [CDataW-1:0] AMosiB,
    output logic              ADoneA,
    output logic              ADoneB,
    output logic [CDataW-1:0] AMiso,
    output logic              AErr,
    output logic              ABusy,
    input  logic              AReconfigReq,
    output logic              ORsuReadParam,
    output logic              ORsuWriteParam,
    output logic [CParamW-1:0] ORsuParam,
    output logic [CSrcW-1:0]  ORsuSrc,
    output logic [CDataW-1:0] ORsuDataIn,
    input  logic              IRsuBusy,
    input  logic [CDataW-1:0] IRsuDataOut,
    output logic              ORsuResetTimer,
    output logic              ORsuReconfig
);

    localparam int unsigned CCntW = $clog2(CTimeout + 1);

    state_e             state_r;
    logic [CCntW-1:0]   wait_cnt_r;
    logic [CCntW-1:0]   wait_next_s;
    logic               wait_done_s;
    logic               wait_tmo_s;
    logic               grant_id_r;
    logic               wr_r;
    logic               pending_r;
    logic               sel_wr_s;
    logic [CParamW-1:0] sel_param_s;
    logic [CSrcW-1:0]   sel_src_s;
    logic [CDataW-1:0]  sel_mosi_s;

    assign wait_next_s = wait_cnt_r + CCntW'(1);
    assign wait_done_s = (wait_next_s >= CCntW'(CMinWait)) && !IRsuBusy;
    assign wait_tmo_s  = (wait_next_s == CCntW'(CTimeout - 1)) && IRsuBusy;

    // Fixed-priority request mux: A wins whenever it asks.
    always_comb begin
        sel_wr_s    = AWrB;
        sel_param_s = AParamB;
        sel_src_s   = ASrcB;
        sel_mosi_s  = AMosiB;
        if (AReqA) begin
            sel_wr_s    = AWrA;
            sel_param_s = AParamA;
            sel_src_s   = ASrcA;
            sel_mosi_s  = AMosiA;
        end else begin
            sel_wr_s    = AWrB;
            sel_param_s = AParamB;
            sel_src_s   = ASrcB;
            sel_mosi_s  = AMosiB;
        end
    end

    // Transaction FSM with registered strobes, completion pulses and reconfig gate.
    always_ff @(posedge AClkH or negedge AResetHN) begin
        if (!AResetHN) begin
            state_r        <= ST_IDLE;
            wait_cnt_r     <= '0;
            grant_id_r     <= CReqIdA;
            wr_r           <= 1'b0;
            pending_r      <= 1'b0;
            ADoneA         <= 1'b0;
            ADoneB         <= 1'b0;
            AMiso          <= '0;
            AErr           <= 1'b0;
            ABusy          <= 1'b0;
            ORsuReadParam  <= 1'b0;
            ORsuWriteParam <= 1'b0;
            ORsuParam      <= '0;
            ORsuSrc        <= '0;
            ORsuDataIn     <= '0;
            ORsuReconfig   <= 1'b0;
        end else if (AClkHEn) begin
            if (AReconfigReq) begin
                pending_r <= 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    // A pending reconfig takes this idle slot so it never lands mid-transaction.
                    if (pending_r) begin
                        ORsuReconfig <= 1'b1;
                        pending_r    <= 1'b0;
                    end else if (AReqA || AReqB) begin
                        grant_id_r     <= AReqA ? CReqIdA : CReqIdB;
                        wr_r           <= sel_wr_s;
                        ORsuParam      <= sel_param_s;
                        ORsuSrc        <= sel_src_s;
                        ORsuDataIn     <= sel_mosi_s;
                        ORsuReadParam  <= ~sel_wr_s;
                        ORsuWriteParam <= sel_wr_s;
                        ABusy          <= 1'b1;
                        AErr           <= 1'b0;
                        state_r        <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    ORsuReadParam  <= 1'b0;
                    ORsuWriteParam <= 1'b0;
                    wait_cnt_r     <= '0;
                    state_r        <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (wait_done_s) begin
                        state_r <= ST_CAPTURE;
                    end else if (wait_tmo_s) begin
                        AErr    <= 1'b1;
                        ADoneA  <= (grant_id_r == CReqIdA);
                        ADoneB  <= (grant_id_r == CReqIdB);
                        state_r <= ST_DONE;
                    end else begin
                        wait_cnt_r <= wait_next_s;
                    end
                end
                ST_CAPTURE: begin
                    if (!wr_r) begin
                        AMiso <= IRsuDataOut;
                    end
                    ADoneA  <= (grant_id_r == CReqIdA);
                    ADoneB  <= (grant_id_r == CReqIdB);
                    state_r <= ST_DONE;
                end
                ST_DONE: begin
                    ADoneA  <= 1'b0;
                    ADoneB  <= 1'b0;
                    ABusy   <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    ORsuReadParam  <= 1'b0;
                    ORsuWriteParam <= 1'b0;
                    ADoneA         <= 1'b0;
                    ADoneB         <= 1'b0;
                    ABusy          <= 1'b0;
                    state_r        <= ST_IDLE;
                end
            endcase
        end
    end

    rsu_wdt_counter #(
        .CWidth(CWdtLog)
    ) u_wdt (
        .clk  (AClkH),
        .rst_n(AResetHN),
        .en   (AClkHEn),
        .msb  (ORsuResetTimer)
    );

endmodule
